alu_ctrl_seq: RTL and testbench



---
 rtl/alu_ctrl_seq.sv | 139 +++++++++++++
 tb/tb_alu_ctrl_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with valid/ready handshake.
// Single-cycle ops produce a result one cycle after acceptance. MUL and DIV
// hold the unit busy and present their result exactly MUL_CYCLES or
// DIV_CYCLES cycles after the accepting edge.
module alu_ctrl_seq #(
    parameter int FUNCT_W    = 4,
    parameter int CTRL_W     = 3,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               jr_ctrl,
    output logic               illegal,
    output logic               busy
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              r_state;
    logic [7:0]          r_count;
    logic                r_out_valid;
    logic [CTRL_W-1:0]   r_alu_ctrl;
    logic                r_jr;
    logic                r_illegal;
    logic                r_busy;

    logic [3:0]          w_lo;
    logic                w_hi_zero;
    logic [CTRL_W-1:0]   w_code;
    logic                w_jr;
    logic                w_ill;
    logic                w_multi;
    logic [7:0]          w_lat_m1;
    logic                w_accept;

    assign w_lo      = funct[3:0];
    assign w_hi_zero = ((funct >> 4) == '0);
    assign w_lat_m1  = (w_lo == 4'd5) ? 8'(MUL_CYCLES - 1) : 8'(DIV_CYCLES - 1);

    assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready) && !flush;
    assign w_accept  = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign alu_ctrl  = r_alu_ctrl;
    assign jr_ctrl   = r_jr;
    assign illegal   = r_illegal;
    assign busy      = r_busy;

    // Decode {alu_op, funct}; any set funct bit above bit 3 makes an R-type op illegal.
    always_comb begin
        w_code  = '0;
        w_jr    = 1'b0;
        w_ill   = 1'b0;
        w_multi = 1'b0;
        case (alu_op)
            2'b11: w_code = '0;
            2'b10: w_code = CTRL_W'(4);
            2'b01: w_code = CTRL_W'(1);
            default: begin
                if (!w_hi_zero) begin
                    w_ill = 1'b1;
                end else begin
                    case (w_lo)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4: w_code = CTRL_W'(w_lo);
                        4'd5, 4'd6: begin
                            w_code  = CTRL_W'(w_lo);
                            w_multi = 1'b1;
                        end
                        4'd8:    w_jr  = 1'b1;
                        default: w_ill = 1'b1;
                    endcase
                end
            end
        endcase
    end

    // Control FSM: accept/hold results, and count down multi-cycle ops.
    // r_count holds the number of further WAIT edges before the result appears,
    // so the result lands exactly LAT edges after the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_alu_ctrl  <= '0;
            r_jr        <= 1'b0;
            r_illegal   <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_alu_ctrl  <= '0;
            r_jr        <= 1'b0;
            r_illegal   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_ctrl <= w_code;
                        r_jr       <= w_jr;
                        r_illegal  <= w_ill;
                        if (w_multi) begin
                            r_count     <= w_lat_m1;
                            r_busy      <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_state     <= S_WAIT;
                        end else begin
                            r_out_valid <= 1'b1;
                        end
                    end else if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_count == 8'd0) begin
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed scenarios plus random traffic, checked cycle by
// cycle against a timestamp-based transaction model.
module tb_alu_ctrl_seq;

    localparam int FUNCT_W = 4;
    localparam int CTRL_W  = 3;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    logic               clk = 1'b0;
    logic               reset, flush, in_valid, out_ready;
    logic [1:0]         alu_op;
    logic [FUNCT_W-1:0] funct;
    logic               in_ready, out_valid, jr_ctrl, illegal, busy;
    logic [CTRL_W-1:0]  alu_ctrl;

    alu_ctrl_seq #(
        .FUNCT_W(FUNCT_W), .CTRL_W(CTRL_W),
        .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .jr_ctrl(jr_ctrl), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: result registers plus the absolute cycle a pending MUL/DIV is due.
    int  cyc = 0;
    bit  m_valid, m_jr, m_ill, m_busy;
    int  m_code;
    int  m_due;
    bit  exp_rdy;

    function automatic void ref_decode(input int op, input int f,
                                       output int code, output bit jr, output bit ill,
                                       output int lat);
        code = 0; jr = 0; ill = 0; lat = 1;
        if (op == 3)      code = 0;
        else if (op == 2) code = 4;
        else if (op == 1) code = 1;
        else if (f <= 6) begin
            code = f;
            if (f == 5) lat = MUL_LAT;
            if (f == 6) lat = DIV_LAT;
        end
        else if (f == 8)  jr = 1;
        else              ill = 1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_jr = 0; m_ill = 0; m_busy = 0; m_code = 0; m_due = 0;
    endtask

    task automatic model_edge();
        int code, lat;
        bit jr, ill;
        cyc++;
        if (flush) begin
            model_reset();
        end else if (m_busy) begin
            if (cyc == m_due) begin
                m_busy  = 0;
                m_valid = 1;
            end
        end else if (in_valid && exp_rdy) begin
            ref_decode(int'(alu_op), int'(funct), code, jr, ill, lat);
            m_code = code; m_jr = jr; m_ill = ill;
            if (lat > 1) begin
                m_busy  = 1;
                m_due   = cyc + lat;
                m_valid = 0;
            end else begin
                m_valid = 1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    endtask

    // One clock: inputs are already driven; check in_ready, clock, check outputs.
    task automatic cycle();
        #1;
        exp_rdy = !m_busy && (!m_valid || out_ready) && !flush;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("alu_ctrl",  32'(alu_ctrl),  32'(m_code));
        chk("jr_ctrl",   32'(jr_ctrl),   32'(m_jr));
        chk("illegal",   32'(illegal),   32'(m_ill));
        chk("busy",      32'(busy),      32'(m_busy));
    endtask

    task automatic drive(input bit v, input int op, input int f, input bit rdy);
        in_valid  = v;
        alu_op    = 2'(op);
        funct     = FUNCT_W'(f);
        out_ready = rdy;
        flush     = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 1);
            cycle();
        end
    endtask

    initial begin
        reset = 1; drive(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_alu_ctrl",  32'(alu_ctrl),  0);
        chk("rst_busy",      32'(busy),      0);
        reset = 0;
        @(negedge clk);

        // Single-cycle stream, out_ready held high.
        for (int i = 0; i < 8; i++) begin
            if (i < 5)      drive(1, 0, i, 1);
            else if (i == 5) drive(1, 3, 0, 1);
            else if (i == 6) drive(1, 2, 0, 1);
            else             drive(1, 1, 0, 1);
            cycle();
        end
        idle_cycles(1);

        // MUL then DIV with latency tracked by the model.
        drive(1, 0, 5, 1); cycle();
        idle_cycles(MUL_LAT + 1);
        drive(1, 0, 6, 1); cycle();
        idle_cycles(DIV_LAT + 1);

        // Back-pressure: hold result of funct 3 for 5 cycles, then release.
        drive(1, 0, 3, 1); cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0); cycle();
        end
        drive(1, 0, 2, 1); cycle();
        idle_cycles(1);

        // JR / illegal / non-R-type with funct 8.
        drive(1, 0, 8, 1); cycle();
        drive(1, 0, 9, 1); cycle();
        drive(1, 1, 8, 1); cycle();
        drive(1, 0, 7, 1); cycle();
        idle_cycles(1);

        // Flush in the middle of a DIV; no late result, then a new op.
        drive(1, 0, 6, 1); cycle();
        idle_cycles(4);
        drive(0, 0, 0, 1); flush = 1; cycle();
        idle_cycles(DIV_LAT + 2);
        drive(1, 0, 4, 1); cycle();
        idle_cycles(1);

        // Flush together with a held result: the result is discarded.
        drive(1, 0, 2, 1); cycle();
        drive(0, 0, 0, 1); flush = 1; cycle();
        idle_cycles(1);

        // Asynchronous reset two cycles into a MUL.
        drive(1, 0, 5, 1); cycle();
        idle_cycles(2);
        #2 reset = 1;
        #1;
        chk("arst_busy",      32'(busy),      0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_alu_ctrl",  32'(alu_ctrl),  0);
        model_reset();
        @(negedge clk);
        reset = 0;
        idle_cycles(MUL_LAT + 2);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 4) != 0, int'($urandom % 4),
                  (($urandom % 4) == 0) ? int'($urandom_range(5, 6)) : int'($urandom % 16),
                  ($urandom % 4) != 0);
            flush = (($urandom % 25) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
